// File: rtl/dmem_resp.sv
// dmem_resp: word-organised data RAM with byte strobes, standing in for external data memory.
// Independent read and write channels, each acknowledging after a fixed number of wait states.
module dmem_resp #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h2000_0000,
  parameter int unsigned RD_WAIT = 0,
  parameter int unsigned WR_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wready,
  output logic        wvalid,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        rready,
  output logic        rvalid,
  input  logic [31:0] raddr,
  output logic        rresp,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] err_addr
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  logic [3:0]  wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic        rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic [29:0] woff, roff;
  logic        w_in, r_in;

  // Word offset from the window base; wraps huge for addresses below BASE, so one compare suffices.
  assign woff = waddr[31:2] - BASE[31:2];
  assign roff = raddr[31:2] - BASE[31:2];
  assign w_in = woff < 30'(DEPTH);
  assign r_in = roff < 30'(DEPTH);

  assign wvalid = wready && (wcnt_q == 4'(WR_WAIT));
  assign rvalid = rready && (rcnt_q == 4'(RD_WAIT));

  always_comb begin
    wcnt_d     = (!wready || wvalid) ? 4'd0 : wcnt_q + 4'd1;
    rcnt_d     = (!rready || rvalid) ? 4'd0 : rcnt_q + 4'd1;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    // Read samples the RAM before this edge's write lands, giving read-first ordering.
    if (rvalid) begin
      rresp_d = r_in;
      rdata_d = r_in ? mem[roff[AW-1:0]] : 32'd0;
    end
    // Write error wins when both channels fault in the same cycle.
    if (!err_q) begin
      if (wvalid && !w_in) begin
        err_d      = 1'b1;
        err_addr_d = waddr;
      end else if (rvalid && !r_in) begin
        err_d      = 1'b1;
        err_addr_d = raddr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q     <= 4'd0;
      rcnt_q     <= 4'd0;
      rresp_q    <= 1'b0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // RAM has no reset; a transfer coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && wvalid && w_in) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[woff[AW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rresp    = rresp_q;
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;
endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: zero-wait, multi-wait and reset-during-count instances.
module tb_dmem_resp;
  localparam logic [31:0] BASE = 32'h2000_0000;

  logic clk = 1'b0;
  logic rst, rst_c;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // Instance a: default depth, no wait states
  logic a_wready, a_wvalid, a_rready, a_rvalid, a_rresp, a_err;
  logic [31:0] a_waddr, a_wdata, a_raddr, a_rdata, a_err_addr;
  logic [3:0]  a_wstrb;
  dmem_resp #(.DEPTH(1024), .BASE(BASE), .RD_WAIT(0), .WR_WAIT(0)) dut_a (
    .clk(clk), .reset(rst), .wready(a_wready), .wvalid(a_wvalid), .waddr(a_waddr),
    .wdata(a_wdata), .wstrb(a_wstrb), .rready(a_rready), .rvalid(a_rvalid), .raddr(a_raddr),
    .rresp(a_rresp), .rdata(a_rdata), .err(a_err), .err_addr(a_err_addr));

  // Instance b: RD_WAIT=3, WR_WAIT=2
  logic b_wready, b_wvalid, b_rready, b_rvalid, b_rresp, b_err;
  logic [31:0] b_waddr, b_wdata, b_raddr, b_rdata, b_err_addr;
  logic [3:0]  b_wstrb;
  dmem_resp #(.DEPTH(16), .BASE(BASE), .RD_WAIT(3), .WR_WAIT(2)) dut_b (
    .clk(clk), .reset(rst), .wready(b_wready), .wvalid(b_wvalid), .waddr(b_waddr),
    .wdata(b_wdata), .wstrb(b_wstrb), .rready(b_rready), .rvalid(b_rvalid), .raddr(b_raddr),
    .rresp(b_rresp), .rdata(b_rdata), .err(b_err), .err_addr(b_err_addr));

  // Instance c: RD_WAIT=5, own reset
  logic c_wready, c_wvalid, c_rready, c_rvalid, c_rresp, c_err;
  logic [31:0] c_waddr, c_wdata, c_raddr, c_rdata, c_err_addr;
  logic [3:0]  c_wstrb;
  dmem_resp #(.DEPTH(16), .BASE(BASE), .RD_WAIT(5), .WR_WAIT(0)) dut_c (
    .clk(clk), .reset(rst_c), .wready(c_wready), .wvalid(c_wvalid), .waddr(c_waddr),
    .wdata(c_wdata), .wstrb(c_wstrb), .rready(c_rready), .rvalid(c_rvalid), .raddr(c_raddr),
    .rresp(c_rresp), .rdata(c_rdata), .err(c_err), .err_addr(c_err_addr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rst_c = 1'b1;
    a_wready = 0; a_rready = 0; a_waddr = 0; a_wdata = 0; a_wstrb = 0; a_raddr = 0;
    b_wready = 0; b_rready = 0; b_waddr = 0; b_wdata = 0; b_wstrb = 0; b_raddr = 0;
    c_wready = 0; c_rready = 0; c_waddr = 0; c_wdata = 0; c_wstrb = 0; c_raddr = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wvalid", 32'(a_wvalid), 32'd0);
    chk("rst_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_rresp", 32'(a_rresp), 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_err_addr", a_err_addr, 32'd0);

    // Zero-wait write then read
    @(negedge clk); rst = 0; rst_c = 0;
    a_wready = 1; a_waddr = BASE + 32'h10; a_wdata = 32'hDEADBEEF; a_wstrb = 4'hF;
    #1 chk("a_wvalid_same_cycle", 32'(a_wvalid), 32'd1);
    @(negedge clk); a_wready = 0; a_rready = 1; a_raddr = BASE + 32'h10;
    #1 chk("a_rvalid_same_cycle", 32'(a_rvalid), 32'd1);
    @(negedge clk); a_rready = 0;
    #1 chk("a_rdata_beef", a_rdata, 32'hDEADBEEF);
    chk("a_rresp_ok", 32'(a_rresp), 32'd1);
    chk("a_rvalid_idle", 32'(a_rvalid), 32'd0);

    // Back-to-back writes, second with partial strobes
    @(negedge clk); a_wready = 1; a_waddr = BASE + 32'h14; a_wdata = 32'h11223344; a_wstrb = 4'hF;
    #1 chk("a_wvalid_b2b0", 32'(a_wvalid), 32'd1);
    @(negedge clk); a_wdata = 32'hAABBCCDD; a_wstrb = 4'b0101;
    #1 chk("a_wvalid_b2b1", 32'(a_wvalid), 32'd1);
    @(negedge clk); a_wready = 0; a_rready = 1; a_raddr = BASE + 32'h14;
    @(negedge clk); a_rready = 0;
    #1 chk("a_strb_merge", a_rdata, 32'h11BB33DD);

    // Out-of-window read, then out-of-window write
    @(negedge clk); a_wready = 1; a_waddr = BASE; a_wdata = 32'h12345678; a_wstrb = 4'hF;
    @(negedge clk); a_wready = 0; a_rready = 1; a_raddr = BASE + 32'd4096;
    #1 chk("a_oow_rvalid", 32'(a_rvalid), 32'd1);
    @(negedge clk); a_rready = 0;
    a_wready = 1; a_waddr = 32'h0; a_wdata = 32'hFFFFFFFF; a_wstrb = 4'hF;
    #1 chk("a_oow_rresp", 32'(a_rresp), 32'd0);
    chk("a_oow_rdata", a_rdata, 32'd0);
    chk("a_oow_err", 32'(a_err), 32'd1);
    chk("a_oow_err_addr", a_err_addr, 32'h2000_1000);
    chk("a_oow_wvalid", 32'(a_wvalid), 32'd1);
    @(negedge clk); a_wready = 0; a_rready = 1; a_raddr = BASE;
    @(negedge clk); a_rready = 0;
    #1 chk("a_err_addr_kept", a_err_addr, 32'h2000_1000);
    chk("a_err_sticky", 32'(a_err), 32'd1);
    chk("a_ram_untouched", a_rdata, 32'h12345678);
    chk("a_rresp_back_ok", 32'(a_rresp), 32'd1);

    // Same-cycle read and write to one word: read-first
    @(negedge clk); a_wready = 1; a_waddr = BASE + 32'h20; a_wdata = 32'h5;
    @(negedge clk); a_wdata = 32'h9; a_rready = 1; a_raddr = BASE + 32'h20;
    @(negedge clk); a_wready = 0;
    #1 chk("a_read_first_old", a_rdata, 32'h5);
    @(negedge clk); a_rready = 0;
    #1 chk("a_read_first_new", a_rdata, 32'h9);

    // Wait states: write acked on cycle 3, read on cycle 4
    @(negedge clk); b_wready = 1; b_waddr = BASE + 32'h8; b_wdata = 32'hCAFEF00D; b_wstrb = 4'hF;
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) @(negedge clk);
      #1 chk($sformatf("b_wvalid_c%0d", i), 32'(b_wvalid), 32'(i == 3));
    end
    @(negedge clk); b_wready = 0; b_rready = 1; b_raddr = BASE + 32'h8;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clk);
      #1 chk($sformatf("b_rvalid_c%0d", i), 32'(b_rvalid), 32'(i == 4));
    end
    @(negedge clk); b_rready = 0;
    #1 chk("b_rdata", b_rdata, 32'hCAFEF00D);
    chk("b_rresp", 32'(b_rresp), 32'd1);
    // Abandoned read: two cycles then drop
    @(negedge clk); b_rready = 1;
    #1 chk("b_abandon_c1", 32'(b_rvalid), 32'd0);
    @(negedge clk);
    #1 chk("b_abandon_c2", 32'(b_rvalid), 32'd0);
    @(negedge clk); b_rready = 0;
    #1 chk("b_abandon_rdata", b_rdata, 32'hCAFEF00D);
    // Counter must restart from zero: ack again on cycle 4
    @(negedge clk); b_rready = 1;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clk);
      #1 chk($sformatf("b_restart_c%0d", i), 32'(b_rvalid), 32'(i == 4));
    end
    @(negedge clk); b_rready = 0;

    // Reset during a RD_WAIT=5 count, with a write in the reset cycle
    @(negedge clk); c_wready = 1; c_waddr = BASE; c_wdata = 32'h77; c_wstrb = 4'hF;
    @(negedge clk); c_wready = 0; c_rready = 1; c_raddr = BASE;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) @(negedge clk);
      #1 chk($sformatf("c_rvalid_k%0d", k), 32'(c_rvalid), 32'(k == 5));
    end
    @(negedge clk);
    #1 chk("c_rdata_pre", c_rdata, 32'h77);
    chk("c_rresp_pre", 32'(c_rresp), 32'd1);
    @(negedge clk);
    @(negedge clk); rst_c = 1; c_wready = 1; c_wdata = 32'h99;
    @(negedge clk); rst_c = 0; c_wready = 0;
    #1 chk("c_post_rst_rvalid", 32'(c_rvalid), 32'd0);
    chk("c_post_rst_rdata", c_rdata, 32'd0);
    chk("c_post_rst_rresp", 32'(c_rresp), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      #1 chk($sformatf("c_rst_rvalid_k%0d", k), 32'(c_rvalid), 32'(k == 5));
    end
    @(negedge clk); c_rready = 0;
    #1 chk("c_rst_write_dropped", c_rdata, 32'h77);
    chk("c_rresp_after", 32'(c_rresp), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
